// File: rtl/ring_cnt_pkg.sv
// Shared constants and pure functions for the generic ring / Johnson counter.
// Vectors are carried at RC_MAX_W bits; callers pass the real width and truncate.
package ring_cnt_pkg;

  localparam int RC_MODE_RING    = 0;
  localparam int RC_MODE_JOHNSON = 1;
  localparam int RC_MAX_W        = 64;

  typedef logic [RC_MAX_W-1:0] rc_vec_t;

  function automatic rc_vec_t width_mask(input int width);
    return ~({RC_MAX_W{1'b1}} << width);
  endfunction

  function automatic rc_vec_t home_pattern(input int width, input int mode);
    return (mode == RC_MODE_RING) ? (rc_vec_t'(1) & width_mask(width)) : '0;
  endfunction

  // Johnson mode feeds back the inverted end bit, ring mode feeds it back unchanged.
  function automatic rc_vec_t next_state(input rc_vec_t q, input logic dir,
                                         input int mode, input int width);
    logic    twist;
    logic    fb;
    rc_vec_t r;
    twist = (mode == RC_MODE_JOHNSON);
    if (!dir) begin
      fb = (|(q & (rc_vec_t'(1) << (width - 1)))) ^ twist;
      r  = ((q << 1) | rc_vec_t'(fb)) & width_mask(width);
    end else begin
      fb = q[0] ^ twist;
      r  = ((q & width_mask(width)) >> 1) | (rc_vec_t'(fb) << (width - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_cnt_decode.sv
// Combinational decode of a ring / Johnson state into a step index and a validity flag.
module ring_cnt_decode
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = RC_MODE_RING,
  parameter int POS_W = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  output logic [POS_W-1:0] pos_o,
  output logic             illegal_o
);

  always_comb begin
    int ones;
    int edges;
    int idx;
    ones      = 0;
    edges     = 0;
    idx       = 0;
    pos_o     = '0;
    illegal_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_i[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (q_i[i] != q_i[i+1]) edges = edges + 1;
    end
    if (MODE == RC_MODE_RING) begin
      illegal_o = (ones != 1);
      pos_o     = POS_W'(idx);
    end else begin
      // Filling phase counts ones upward; emptying phase (MSB set) counts down from 2*WIDTH.
      illegal_o = (edges > 1);
      pos_o     = q_i[WIDTH-1] ? POS_W'(2*WIDTH - ones) : POS_W'(ones);
    end
    if (illegal_o) pos_o = '0;
  end

endmodule

// File: rtl/ring_counter_gen.sv
// Parametrised one-hot ring / Johnson counter with load, direction and wrap pulse.
// Define RING_CNT_SELF_CORRECT_EN to force an illegal state back to HOME on an enabled edge.
module ring_counter_gen
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = RC_MODE_RING,
  parameter int POS_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] HOME = WIDTH'(home_pattern(WIDTH, MODE));

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shift_val;
  logic             wrap_q, wrap_d;

  assign shift_val = WIDTH'(next_state(rc_vec_t'(q_q), dir, MODE, WIDTH));

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
`ifdef RING_CNT_SELF_CORRECT_EN
      if (illegal) begin
        q_d = HOME;
      end else begin
        q_d    = shift_val;
        wrap_d = (shift_val == HOME) && (q_q != HOME);
      end
`else
      q_d    = shift_val;
      wrap_d = (shift_val == HOME) && (q_q != HOME);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= HOME;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  ring_cnt_decode #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .POS_W (POS_W)
  ) u_decode (
    .q_i       (q_q),
    .pos_o     (pos),
    .illegal_o (illegal)
  );

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Bench for ring_counter_gen: a ring and a Johnson instance share stimulus and are
// compared every cycle against a code-table model of the counting sequence.
module tb_ring_counter_gen;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int PW   = $clog2(2*W);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          dir;
  logic          load;
  logic [W-1:0]  load_val;

  logic [W-1:0]  q_r, q_j;
  logic [PW-1:0] pos_r, pos_j;
  logic          wrap_r, wrap_j, ill_r, ill_j;

  int            n_checks = 0;
  int            n_err    = 0;
  int            mq[2];
  bit            mw[2];
  logic [W-1:0]  john_exp[8];

  always #5 clk = ~clk;

  ring_counter_gen #(.WIDTH(W), .MODE(0)) dut_ring (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .q(q_r), .pos(pos_r), .wrap(wrap_r), .illegal(ill_r)
  );

  ring_counter_gen #(.WIDTH(W), .MODE(1)) dut_john (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .q(q_j), .pos(pos_j), .wrap(wrap_j), .illegal(ill_j)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Valid codes listed in step order: step k of the sequence is code_of(k).
  function automatic int code_of(input int k, input int m);
    if (m == 0) return 1 << k;
    if (k <= W) return (1 << k) - 1;
    return (((1 << W) - 1) << (k - W)) & MASK;
  endfunction

  function automatic int period(input int m);
    return (m == 0) ? W : 2*W;
  endfunction

  function automatic int idx_of(input int v, input int m);
    for (int k = 0; k < period(m); k++)
      if (code_of(k, m) == v) return k;
    return -1;
  endfunction

  function automatic int raw_shift(input int v, input bit d, input int m);
    int msb;
    int lsb;
    msb = (v >> (W - 1)) & 1;
    lsb = v & 1;
    if (!d) return ((v << 1) & MASK) | ((m == 1) ? (msb ^ 1) : msb);
    return (v >> 1) | (((m == 1) ? (lsb ^ 1) : lsb) << (W - 1));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m] = code_of(0, m);
      mw[m] = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit d, input bit l, input int v);
    for (int m = 0; m < 2; m++) begin
      int k;
      int nq;
      int home;
      bit corrected;
      home      = code_of(0, m);
      corrected = 1'b0;
      if (l) begin
        mq[m] = v;
        mw[m] = 1'b0;
      end else if (e) begin
        k = idx_of(mq[m], m);
        if (k >= 0) begin
          k  = d ? (k + period(m) - 1) % period(m) : (k + 1) % period(m);
          nq = code_of(k, m);
        end else begin
`ifdef RING_CNT_SELF_CORRECT_EN
          nq        = home;
          corrected = 1'b1;
`else
          nq = raw_shift(mq[m], d, m);
`endif
        end
        mw[m] = !corrected && (nq == home) && (mq[m] != home);
        mq[m] = nq;
      end else begin
        mw[m] = 1'b0;
      end
    end
  endtask

  task automatic compare_one(input string name, input int m, input logic [W-1:0] gq,
                             input logic [PW-1:0] gp, input logic gw, input logic gi);
    int k;
    k = idx_of(mq[m], m);
    check_eq($sformatf("%s.q", name), 32'(gq), 32'(mq[m]));
    check_eq($sformatf("%s.pos", name), 32'(gp), (k < 0) ? 32'd0 : 32'(k));
    check_eq($sformatf("%s.wrap", name), 32'(gw), 32'(mw[m]));
    check_eq($sformatf("%s.illegal", name), 32'(gi), 32'(k < 0));
  endtask

  task automatic compare_all();
    compare_one("ring", 0, q_r, pos_r, wrap_r, ill_r);
    compare_one("john", 1, q_j, pos_j, wrap_j, ill_j);
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic cycle(input bit e, input bit d, input bit l, input logic [W-1:0] v);
    en = e; dir = d; load = l; load_val = v;
    @(posedge clk);
    model_step(e, d, l, int'(v));
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_async.q", 32'(q_r), 32'd1);
    check_eq("rst_async.wrap", 32'(wrap_r), 32'd0);
    compare_all();
    en = 1'b0; load = 1'b0;
    #1 rst = 1'b0;
  endtask

  initial begin
    john_exp[0] = 4'b0001; john_exp[1] = 4'b0011; john_exp[2] = 4'b0111; john_exp[3] = 4'b1111;
    john_exp[4] = 4'b1110; john_exp[5] = 4'b1100; john_exp[6] = 4'b1000; john_exp[7] = 4'b0000;
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();

    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      check_eq("ring_seq", 32'(q_r), 32'(1 << (i % 4)));
      check_eq("ring_seq_wrap", 32'(wrap_r), 32'(i % 4 == 0));
      check_eq("john_seq", 32'(q_j), 32'(john_exp[i-1]));
    end

    cycle(1'b0, 1'b0, 1'b1, 4'b0100);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("ring_dir1_wrap", 32'(wrap_r), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);

    cycle(1'b0, 1'b0, 1'b1, 4'b0110);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 4'b1000);
    check_eq("load_wins", 32'(q_r), 32'h8);

    cycle(1'b1, 1'b0, 1'b0, '0);
    reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 4'b0100);
    reset_mid();
    cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);

    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] v;
      bit           l;
      l = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1) v = W'($urandom_range(0, MASK));
      else                            v = W'(code_of($urandom_range(0, 2*W - 1), 1));
      if ($urandom_range(0, 59) == 0) reset_mid();
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), l, v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
